// File: rtl/dwc_ctrl_pkg.sv
// Shared types and helpers for the dwc_mem sequencing controller.
package dwc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam int unsigned MAX_RETRY_DEF = 32'd2;

  // Width of a counter able to hold 0..max_retry (at least one bit).
  function automatic int unsigned retry_cnt_w(input int unsigned max_retry);
    if (max_retry < 32'd1) begin
      retry_cnt_w = 32'd1;
    end else begin
      retry_cnt_w = $clog2(max_retry + 32'd1);
    end
  endfunction

endpackage

// File: rtl/dwc_sat_cnt.sv
// Increment-enable saturating counter; sticks at all-ones.
module dwc_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: add one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dwc_mem_ctrl.sv
// Sequencing controller in front of a duplicated-with-comparison memory.
// Serialises client reads/writes, re-reads on copy mismatch, reports
// uncorrectable reads and tracks mismatch statistics.
// Optional build macro: DWC_MEM_INIT_EN -- after reset, sweep INIT_VAL into
// every address before accepting traffic.
module dwc_mem_ctrl
  import dwc_ctrl_pkg::*;
#(
  parameter int unsigned     BITS      = 8,
  parameter int unsigned     WORDS     = 4,
  parameter int unsigned     ADDRESS   = $clog2(WORDS),
  parameter int unsigned     MAX_RETRY = MAX_RETRY_DEF,
  parameter int unsigned     CNT_W     = 8,
  parameter logic [BITS-1:0] INIT_VAL  = {BITS{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDRESS-1:0] req_addr,
  input  logic [BITS-1:0]    req_wdata,
  output logic               rsp_valid,
  output logic [BITS-1:0]    rsp_data,
  output logic               rsp_err,
  output logic               mem_w_enbl,
  output logic [ADDRESS-1:0] mem_w_addr,
  output logic [BITS-1:0]    mem_w_data,
  output logic [ADDRESS-1:0] mem_r_addr,
  input  logic [BITS-1:0]    mem_r_data,
  input  logic               mem_error,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ADDRESS-1:0] last_err_addr,
  output logic               init_done
);

  localparam int unsigned       RW          = retry_cnt_w(MAX_RETRY);
  localparam logic [RW-1:0]     MAX_RETRY_C = RW'(MAX_RETRY);
  localparam logic [ADDRESS:0]  INIT_END    = (ADDRESS + 1)'(WORDS);
`ifdef DWC_MEM_INIT_EN
  localparam state_t            RST_STATE   = ST_INIT;
`else
  localparam state_t            RST_STATE   = ST_IDLE;
`endif

  state_t             state_q, state_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [ADDRESS:0]   init_idx_q, init_idx_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]    rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               mem_w_enbl_q, mem_w_enbl_d;
  logic [ADDRESS-1:0] mem_w_addr_q, mem_w_addr_d;
  logic [BITS-1:0]    mem_w_data_q, mem_w_data_d;
  logic [ADDRESS-1:0] mem_r_addr_q, mem_r_addr_d;
  logic [ADDRESS-1:0] last_err_addr_q, last_err_addr_d;
  logic               init_done_q, init_done_d;
  logic               err_inc;
  logic               accept;

  // A request is taken only while idle and advertising ready.
  assign accept = req_valid && req_ready_q && (state_q == ST_IDLE);

  // FSM state register; reset lands in the start state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (init_idx_q == INIT_END) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = req_we ? ST_WR : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_RD:   state_d = ST_CHK;
      ST_CHK: begin
        if (mem_error && (retry_q < MAX_RETRY_C)) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Output / datapath next values for every registered output.
  always_comb begin
    retry_d         = retry_q;
    init_idx_d      = init_idx_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    mem_w_enbl_d    = 1'b0;
    mem_w_addr_d    = mem_w_addr_q;
    mem_w_data_d    = mem_w_data_q;
    mem_r_addr_d    = mem_r_addr_q;
    last_err_addr_d = last_err_addr_q;
    err_inc         = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_idx_q != INIT_END) begin
          mem_w_enbl_d = 1'b1;
          mem_w_addr_d = init_idx_q[ADDRESS-1:0];
          mem_w_data_d = INIT_VAL;
          init_idx_d   = init_idx_q + (ADDRESS + 1)'(1);
        end else begin
          init_idx_d   = init_idx_q;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          retry_d = {RW{1'b0}};
          if (req_we) begin
            mem_w_enbl_d = 1'b1;
            mem_w_addr_d = req_addr;
            mem_w_data_d = req_wdata;
          end else begin
            mem_r_addr_d = req_addr;
          end
        end else begin
          retry_d = retry_q;
        end
      end
      ST_WR: begin
        mem_w_enbl_d = 1'b0;
      end
      ST_RD: begin
        mem_r_addr_d = mem_r_addr_q;
      end
      ST_CHK: begin
        if (mem_error) begin
          err_inc         = 1'b1;
          last_err_addr_d = mem_r_addr_q;
          if (retry_q < MAX_RETRY_C) begin
            retry_d = retry_q + RW'(1);
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = mem_r_data;
          end
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = mem_r_data;
        end
      end
      default: begin
        mem_w_enbl_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
`ifdef DWC_MEM_INIT_EN
    init_done_d = (state_d != ST_INIT);
`else
    init_done_d = 1'b1;
`endif
  end

  // Registered outputs and controller context, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q         <= {RW{1'b0}};
      init_idx_q      <= {(ADDRESS + 1){1'b0}};
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= {BITS{1'b0}};
      rsp_err_q       <= 1'b0;
      mem_w_enbl_q    <= 1'b0;
      mem_w_addr_q    <= {ADDRESS{1'b0}};
      mem_w_data_q    <= {BITS{1'b0}};
      mem_r_addr_q    <= {ADDRESS{1'b0}};
      last_err_addr_q <= {ADDRESS{1'b0}};
      init_done_q     <= 1'b0;
    end else begin
      retry_q         <= retry_d;
      init_idx_q      <= init_idx_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      mem_w_enbl_q    <= mem_w_enbl_d;
      mem_w_addr_q    <= mem_w_addr_d;
      mem_w_data_q    <= mem_w_data_d;
      mem_r_addr_q    <= mem_r_addr_d;
      last_err_addr_q <= last_err_addr_d;
      init_done_q     <= init_done_d;
    end
  end

  dwc_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign mem_w_enbl    = mem_w_enbl_q;
  assign mem_w_addr    = mem_w_addr_q;
  assign mem_w_data    = mem_w_data_q;
  assign mem_r_addr    = mem_r_addr_q;
  assign last_err_addr = last_err_addr_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_dwc_mem_ctrl.sv
// Randomised self-checking bench for dwc_mem_ctrl with a request-level
// reference model and a behavioural stand-in for dwc_mem.
module tb_dwc_mem_ctrl;

  localparam int BITS      = 8;
  localparam int WORDS     = 4;
  localparam int ADDRESS   = $clog2(WORDS);
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [ADDRESS-1:0] req_addr;
  logic [BITS-1:0]    req_wdata;
  logic               rsp_valid;
  logic [BITS-1:0]    rsp_data;
  logic               rsp_err;
  logic               mem_w_enbl;
  logic [ADDRESS-1:0] mem_w_addr;
  logic [BITS-1:0]    mem_w_data;
  logic [ADDRESS-1:0] mem_r_addr;
  logic [BITS-1:0]    mem_r_data;
  logic               mem_error;
  logic [CNT_W-1:0]   err_cnt;
  logic [ADDRESS-1:0] last_err_addr;
  logic               init_done;

  // Behavioural memory (copy 0) driven by the controller's write port.
  logic [BITS-1:0] bmem [WORDS];

  // Reference model state, updated per accepted request.
  logic [BITS-1:0]    mdl_mem [WORDS];
  int                 mdl_cnt;
  logic [ADDRESS-1:0] mdl_last;

  int n_chk;
  int n_pass;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_enbl) bmem[mem_w_addr] <= mem_w_data;
  end

  assign mem_r_data = bmem[mem_r_addr];

  dwc_mem_ctrl #(
    .BITS      (BITS),
    .WORDS     (WORDS),
    .ADDRESS   (ADDRESS),
    .MAX_RETRY (MAX_RETRY),
    .CNT_W     (CNT_W),
    .INIT_VAL  (8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .mem_w_enbl    (mem_w_enbl),
    .mem_w_addr    (mem_w_addr),
    .mem_w_data    (mem_w_data),
    .mem_r_addr    (mem_r_addr),
    .mem_r_data    (mem_r_data),
    .mem_error     (mem_error),
    .err_cnt       (err_cnt),
    .last_err_addr (last_err_addr),
    .init_done     (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, req_ready, rsp_valid, rsp_data, rsp_err, mem_w_enbl, mem_w_addr,
            mem_w_data, mem_r_addr, err_cnt, last_err_addr, init_done};
  endfunction

  // Called at a negedge right after rst_n is released.
  task automatic after_reset();
`ifdef DWC_MEM_INIT_EN
    for (int c = 1; c <= WORDS; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("init_wen",   32'(mem_w_enbl), 32'd1);
      chk("init_waddr", 32'(mem_w_addr), 32'(c - 1));
      chk("init_wdata", 32'(mem_w_data), 32'd0);
      chk("init_rdy",   32'(req_ready),  32'd0);
      chk("init_done0", 32'(init_done),  32'd0);
    end
    for (int i = 0; i < WORDS; i++) mdl_mem[i] = 8'h00;
`endif
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_rdy",  32'(req_ready),  32'd1);
    chk("post_rst_done", 32'(init_done),  32'd1);
    chk("post_rst_wen",  32'(mem_w_enbl), 32'd0);
    chk("post_rst_rsp",  32'(rsp_valid),  32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_rdy", 32'(req_ready),  32'd1);
      chk("idle_rsp", 32'(rsp_valid),  32'd0);
      chk("idle_wen", 32'(mem_w_enbl), 32'd0);
    end
  endtask

  // One client request; k = number of leading mismatching samples (0..MAX_RETRY+1).
  task automatic run_req(input logic we, input logic [ADDRESS-1:0] addr,
                         input logic [BITS-1:0] wd, input int k);
    int            attempts;
    int            nerr;
    int            lat;
    logic          exp_err;
    logic [BITS-1:0] exp_data;
    attempts = (k < MAX_RETRY) ? k + 1 : MAX_RETRY + 1;
    nerr     = (k < MAX_RETRY + 1) ? k : MAX_RETRY + 1;
    exp_err  = (k > MAX_RETRY);
    lat      = we ? 2 : 1 + 2 * attempts;
    exp_data = mdl_mem[addr];
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    mem_error = 1'b0;
    chk("rdy_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    if (we) begin
      mdl_mem[addr] = wd;
    end else begin
      mdl_cnt = (mdl_cnt + nerr > CNT_MAX) ? CNT_MAX : mdl_cnt + nerr;
      if (nerr > 0) mdl_last = addr;
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      // client keeps presenting a (different) pending request while busy
      req_we    = 1'($urandom);
      req_addr  = ADDRESS'($urandom);
      req_wdata = BITS'($urandom);
      if (c == lat) req_valid = 1'b0;
      mem_error = we ? 1'($urandom) : ((c <= 2 * k) ? 1'b1 : 1'b0);
      chk("rdy_busy",  32'(req_ready),  32'(c == lat));
      chk("w_enbl",    32'(mem_w_enbl), 32'(we && (c == 1)));
      chk("rsp_valid", 32'(rsp_valid),  32'(!we && (c == lat)));
      if (we && (c == 1)) begin
        chk("w_addr", 32'(mem_w_addr), 32'(addr));
        chk("w_data", 32'(mem_w_data), 32'(wd));
      end
      if (!we && (c < lat)) begin
        chk("r_addr", 32'(mem_r_addr), 32'(addr));
      end
      if (c == lat) begin
        if (!we) begin
          chk("rsp_data", 32'(rsp_data), 32'(exp_data));
          chk("rsp_err",  32'(rsp_err),  32'(exp_err));
        end
        chk("err_cnt", 32'(err_cnt), 32'(mdl_cnt));
        if (mdl_cnt > 0) chk("last_err_addr", 32'(last_err_addr), 32'(mdl_last));
      end
    end
    mem_error = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    mdl_cnt   = 0;
    mdl_last  = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_error = 1'b0;
    for (int i = 0; i < WORDS; i++) mdl_mem[i] = 8'h00;
    #12;
    chk("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    after_reset();

    // Fill every word, A5 at address 2, then directed read scenarios.
    run_req(1'b1, 2'd0, 8'h3C, 0);
    run_req(1'b1, 2'd1, 8'h96, 0);
    run_req(1'b1, 2'd3, 8'h5A, 0);
    run_req(1'b1, 2'd2, 8'hA5, 0);
    run_req(1'b0, 2'd2, 8'h00, 0);
    run_req(1'b0, 2'd2, 8'h00, 1);
    run_req(1'b0, 2'd1, 8'h00, MAX_RETRY + 1);

    // Randomised traffic with random mismatch patterns and idle gaps.
    for (int n = 0; n < 80; n++) begin
      idle_cycles($urandom_range(0, 2));
      run_req(1'($urandom), ADDRESS'($urandom), BITS'($urandom),
              $urandom_range(0, MAX_RETRY + 1));
    end

    // Drive the mismatch counter well past saturation.
    for (int n = 0; n < 6; n++) begin
      run_req(1'b0, ADDRESS'($urandom), 8'h00, MAX_RETRY + 1);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'(CNT_MAX));

    // Reset in the middle of a read: everything clears at once, no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 2'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_outs", all_outs(), 32'd0);
    rst_n    = 1'b1;
    mdl_cnt  = 0;
    mdl_last = '0;
    after_reset();
    run_req(1'b0, 2'd3, 8'h00, 0);
    run_req(1'b0, 2'd0, 8'h00, 1);
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
